// File: rtl/lzw_pkg.sv
// Shared LZW dictionary types and constants for the encoder, decoder,
// prefix_code_ram and its controller.
package lzw_pkg;

    localparam int unsigned ADDR_W     = 12;
    localparam int unsigned DATA_W     = 13;
    localparam int unsigned FIRST_CODE = 256;

    typedef logic [ADDR_W-1:0] code_t;
    typedef logic [DATA_W-1:0] prefix_t;

    localparam prefix_t EMPTY_MARK   = 13'h1FFF;
    localparam code_t   FIRST_CODE_C = code_t'(FIRST_CODE);
    localparam code_t   LAST_CODE    = '1;

    typedef enum logic [1:0] {
        IDLE,
        INIT,
        RUN
    } ctrl_state_t;

    typedef struct packed {
        logic    en;
        logic    wren;
        code_t   addr;
        prefix_t wdata;
    } ram_cmd_t;

    function automatic ram_cmd_t ram_write(input code_t addr, input prefix_t data);
        ram_cmd_t cmd;
        cmd.en    = 1'b1;
        cmd.wren  = 1'b1;
        cmd.addr  = addr;
        cmd.wdata = data;
        return cmd;
    endfunction

    function automatic ram_cmd_t ram_read(input code_t addr);
        ram_cmd_t cmd;
        cmd.en    = 1'b1;
        cmd.wren  = 1'b0;
        cmd.addr  = addr;
        cmd.wdata = '0;
        return cmd;
    endfunction

endpackage

// File: rtl/prefix_ram_ctrl_rr_arb2.sv
// Two-requester round-robin arbiter. On a contested grant the favoured
// requester wins and priority passes to the other one.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       enable,
    output logic [1:0] gnt
);

    logic pri_q;
    logic pri_d;

    always_comb begin
        gnt   = 2'b00;
        pri_d = pri_q;
        if (enable) begin
            case (req)
                2'b01: gnt = 2'b01;
                2'b10: gnt = 2'b10;
                2'b11: begin
                    gnt   = pri_q ? 2'b10 : 2'b01;
                    pri_d = ~pri_q;
                end
                default: gnt = 2'b00;
            endcase
        end
    end

    // pri_q = 0 favours requester 0
    always_ff @(posedge clk) begin
        if (rst) begin
            pri_q <= 1'b0;
        end else begin
            pri_q <= pri_d;
        end
    end

endmodule

// File: rtl/prefix_ram_ctrl.sv
// Owner of the prefix_code_ram port: dictionary flush sequencer, code
// allocator and read/write round-robin access arbitration.
module prefix_ram_ctrl
    import lzw_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start_init,
    output logic              init_busy,
    input  logic              wr_req,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_gnt,
    output logic [ADDR_W-1:0] wr_code,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_gnt,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic [ADDR_W-1:0] next_code,
    output logic              dict_full,
    output logic              ram_en,
    output logic              ram_wren,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wr_data,
    input  logic [DATA_W-1:0] ram_rd_data
);

    ctrl_state_t state_q, state_d;
    code_t       init_addr_q, init_addr_d;
    code_t       next_code_q, next_code_d;
    logic        dict_full_q, dict_full_d;
    logic        rd_valid_q, rd_valid_d;
    prefix_t     rd_hold_q, rd_hold_d;
    ram_cmd_t    ram_cmd;
    logic        arb_en;
    logic [1:0]  arb_req;
    logic [1:0]  arb_gnt;

    // a clear code in RUN takes the port away from both requesters
    assign arb_en  = (state_q == RUN) && !start_init;
    assign arb_req = {wr_req && !dict_full_q, rd_req};

    rr_arb2 u_arb (
        .clk    (clk),
        .rst    (rst),
        .req    (arb_req),
        .enable (arb_en),
        .gnt    (arb_gnt)
    );

    assign rd_gnt = arb_gnt[0];
    assign wr_gnt = arb_gnt[1];

    always_comb begin
        state_d     = state_q;
        init_addr_d = init_addr_q;
        next_code_d = next_code_q;
        dict_full_d = dict_full_q;
        ram_cmd     = '0;
        wr_code     = '0;
        unique case (state_q)
            IDLE: begin
                if (start_init) begin
                    state_d = INIT;
                end
            end
            INIT: begin
                ram_cmd = ram_write(init_addr_q, EMPTY_MARK);
                if (init_addr_q == LAST_CODE) begin
                    state_d     = RUN;
                    init_addr_d = FIRST_CODE_C;
                    next_code_d = FIRST_CODE_C;
                    dict_full_d = 1'b0;
                end else begin
                    init_addr_d = init_addr_q + code_t'(1);
                end
            end
            RUN: begin
                if (start_init) begin
                    state_d     = INIT;
                    ram_cmd     = ram_write(init_addr_q, EMPTY_MARK);
                    init_addr_d = init_addr_q + code_t'(1);
                end else if (wr_gnt) begin
                    ram_cmd = ram_write(next_code_q, wr_data);
                    wr_code = next_code_q;
                    if (next_code_q == LAST_CODE) begin
                        dict_full_d = 1'b1;
                    end else begin
                        next_code_d = next_code_q + code_t'(1);
                    end
                end else if (rd_gnt) begin
                    ram_cmd = ram_read(rd_addr);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // read return: RAM data passes through while valid, then is held
    always_comb begin
        rd_valid_d = rd_gnt;
        rd_hold_d  = rd_valid_q ? ram_rd_data : rd_hold_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            init_addr_q <= FIRST_CODE_C;
            next_code_q <= FIRST_CODE_C;
            dict_full_q <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_hold_q   <= '0;
        end else begin
            state_q     <= state_d;
            init_addr_q <= init_addr_d;
            next_code_q <= next_code_d;
            dict_full_q <= dict_full_d;
            rd_valid_q  <= rd_valid_d;
            rd_hold_q   <= rd_hold_d;
        end
    end

    assign init_busy   = (state_q == INIT);
    assign rd_valid    = rd_valid_q;
    assign rd_data     = rd_hold_d;
    assign next_code   = next_code_q;
    assign dict_full   = dict_full_q;
    assign ram_en      = ram_cmd.en;
    assign ram_wren    = ram_cmd.wren;
    assign ram_addr    = ram_cmd.addr;
    assign ram_wr_data = ram_cmd.wdata;

endmodule

// File: tb/tb_prefix_ram_ctrl.sv
// Directed bench for prefix_ram_ctrl with a behavioural single-port RAM
// (one-cycle read latency) attached to the RAM port.
module tb_prefix_ram_ctrl;
    import lzw_pkg::*;

    logic          clk = 1'b0;
    logic          rst;
    logic          start_init;
    logic          init_busy;
    logic          wr_req;
    logic [12:0]   wr_data;
    logic          wr_gnt;
    logic [11:0]   wr_code;
    logic          rd_req;
    logic [11:0]   rd_addr;
    logic          rd_gnt;
    logic          rd_valid;
    logic [12:0]   rd_data;
    logic [11:0]   next_code;
    logic          dict_full;
    logic          ram_en;
    logic          ram_wren;
    logic [11:0]   ram_addr;
    logic [12:0]   ram_wr_data;
    logic [12:0]   ram_rd_data;

    logic [12:0]   mem [0:4095];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    prefix_ram_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .start_init  (start_init),
        .init_busy   (init_busy),
        .wr_req      (wr_req),
        .wr_data     (wr_data),
        .wr_gnt      (wr_gnt),
        .wr_code     (wr_code),
        .rd_req      (rd_req),
        .rd_addr     (rd_addr),
        .rd_gnt      (rd_gnt),
        .rd_valid    (rd_valid),
        .rd_data     (rd_data),
        .next_code   (next_code),
        .dict_full   (dict_full),
        .ram_en      (ram_en),
        .ram_wren    (ram_wren),
        .ram_addr    (ram_addr),
        .ram_wr_data (ram_wr_data),
        .ram_rd_data (ram_rd_data)
    );

    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_wren) mem[ram_addr] <= ram_wr_data;
            else          ram_rd_data   <= mem[ram_addr];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Called at negedge with INIT already entered; ends at negedge+1 of first RUN cycle.
    task automatic run_flush(input string tag, input int first_addr, input int exp_cycles);
        int n    = 0;
        int errs = 0;
        #1;
        while (init_busy && n < 5000) begin
            if (ram_en !== 1'b1 || ram_wren !== 1'b1 || ram_addr !== 12'(first_addr + n) ||
                ram_wr_data !== 13'h1FFF || wr_gnt !== 1'b0 || rd_gnt !== 1'b0)
                errs++;
            n++;
            @(negedge clk);
            #1;
        end
        check({tag, "_cycles"}, 32'(n), 32'(exp_cycles));
        check({tag, "_writes"}, 32'(errs), 32'd0);
    endtask

    initial begin
        rst = 1'b1; start_init = 1'b0; wr_req = 1'b0; wr_data = '0;
        rd_req = 1'b0; rd_addr = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_busy",     32'(init_busy),   32'd0);
        check("rst_ram_en",   32'(ram_en),      32'd0);
        check("rst_ram_addr", 32'(ram_addr),    32'd0);
        check("rst_rd_valid", 32'(rd_valid),    32'd0);
        check("rst_rd_data",  32'(rd_data),     32'd0);
        check("rst_next",     32'(next_code),   32'd256);
        check("rst_full",     32'(dict_full),   32'd0);
        check("rst_wr_code",  32'(wr_code),     32'd0);

        // IDLE grants nothing
        rd_req = 1'b1; wr_req = 1'b1; #1;
        check("idle_rd_gnt", 32'(rd_gnt), 32'd0);
        check("idle_wr_gnt", 32'(wr_gnt), 32'd0);
        rd_req = 1'b0; wr_req = 1'b0;

        // first flush from IDLE
        @(negedge clk); start_init = 1'b1;
        @(negedge clk); start_init = 1'b0;
        run_flush("flush1", 256, 3840);
        check("f1_next", 32'(next_code), 32'd256);
        check("f1_full", 32'(dict_full), 32'd0);

        // single insert
        @(negedge clk); wr_req = 1'b1; wr_data = 13'h0041; #1;
        check("ins_gnt",   32'(wr_gnt),      32'd1);
        check("ins_code",  32'(wr_code),     32'd256);
        check("ins_wren",  32'(ram_wren),    32'd1);
        check("ins_addr",  32'(ram_addr),    32'd256);
        check("ins_wdata", 32'(ram_wr_data), 32'h41);
        @(negedge clk); wr_req = 1'b0; #1;
        check("ins_next", 32'(next_code), 32'd257);

        // lookups: 256 then 300, then hold
        rd_req = 1'b1; rd_addr = 12'd256; #1;
        check("rd_gnt",  32'(rd_gnt),   32'd1);
        check("rd_wren", 32'(ram_wren), 32'd0);
        check("rd_addr", 32'(ram_addr), 32'd256);
        @(negedge clk); rd_addr = 12'd300; #1;
        check("rd1_valid", 32'(rd_valid), 32'd1);
        check("rd1_data",  32'(rd_data),  32'h41);
        @(negedge clk); rd_req = 1'b0; #1;
        check("rd2_valid", 32'(rd_valid), 32'd1);
        check("rd2_data",  32'(rd_data),  32'h1FFF);
        @(negedge clk); #1;
        check("rd_hold_valid", 32'(rd_valid), 32'd0);
        check("rd_hold_data",  32'(rd_data),  32'h1FFF);

        // contested: R,W,R,W,R,W
        @(negedge clk); wr_req = 1'b1; rd_req = 1'b1; rd_addr = 12'd256; wr_data = 13'h0100;
        for (int i = 0; i < 6; i++) begin
            #1;
            check($sformatf("rr%0d_rd", i), 32'(rd_gnt), 32'((i % 2) == 0));
            check($sformatf("rr%0d_wr", i), 32'(wr_gnt), 32'((i % 2) == 1));
            if ((i % 2) == 1) check($sformatf("rr%0d_code", i), 32'(wr_code), 32'(257 + i / 2));
            @(negedge clk);
        end
        wr_req = 1'b0; rd_req = 1'b0; #1;
        check("rr_next", 32'(next_code), 32'd260);

        // fill up to 4094
        @(negedge clk); wr_req = 1'b1; wr_data = 13'h0ABC;
        repeat (3834) @(negedge clk);
        wr_req = 1'b0; #1;
        check("pre_next", 32'(next_code), 32'd4094);
        wr_req = 1'b1; wr_data = 13'h0777; #1;
        check("top0_gnt",  32'(wr_gnt),  32'd1);
        check("top0_code", 32'(wr_code), 32'd4094);
        @(negedge clk); #1;
        check("top1_gnt",  32'(wr_gnt),    32'd1);
        check("top1_code", 32'(wr_code),   32'd4095);
        check("top1_full", 32'(dict_full), 32'd0);
        @(negedge clk); rd_req = 1'b1; rd_addr = 12'd256; #1;
        check("full_flag",   32'(dict_full), 32'd1);
        check("full_next",   32'(next_code), 32'd4095);
        check("full_wr_gnt", 32'(wr_gnt),    32'd0);
        check("full_rd_gnt", 32'(rd_gnt),    32'd1);

        // clear code right after a granted read
        @(negedge clk); wr_req = 1'b0; start_init = 1'b1; #1;
        check("clr_rd_valid", 32'(rd_valid),    32'd1);
        check("clr_rd_data",  32'(rd_data),     32'h41);
        check("clr_rd_gnt",   32'(rd_gnt),      32'd0);
        check("clr_wren",     32'(ram_wren),    32'd1);
        check("clr_addr",     32'(ram_addr),    32'd256);
        check("clr_wdata",    32'(ram_wr_data), 32'h1FFF);
        @(negedge clk); start_init = 1'b0; rd_req = 1'b0;
        run_flush("flush2", 257, 3839);
        check("f2_full", 32'(dict_full), 32'd0);
        check("f2_next", 32'(next_code), 32'd256);

        // reset with a read in flight
        @(negedge clk); rd_req = 1'b1; rd_addr = 12'd256; rst = 1'b1;
        @(negedge clk); rst = 1'b0; rd_req = 1'b0; #1;
        check("rstrd_valid", 32'(rd_valid), 32'd0);
        check("rstrd_data",  32'(rd_data),  32'd0);

        // reset mid-flush
        @(negedge clk); start_init = 1'b1;
        @(negedge clk); start_init = 1'b0;
        repeat (10) @(negedge clk);
        #1;
        check("mid_busy", 32'(init_busy), 32'd1);
        check("mid_addr", 32'(ram_addr),  32'd266);
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0; #1;
        check("rstmid_busy",  32'(init_busy),   32'd0);
        check("rstmid_en",    32'(ram_en),      32'd0);
        check("rstmid_addr",  32'(ram_addr),    32'd0);
        check("rstmid_wdata", 32'(ram_wr_data), 32'd0);
        check("rstmid_next",  32'(next_code),   32'd256);
        check("rstmid_full",  32'(dict_full),   32'd0);
        @(negedge clk); start_init = 1'b1;
        @(negedge clk); start_init = 1'b0; #1;
        check("restart_addr", 32'(ram_addr), 32'd256);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
